// File: rtl/priority_router.sv
// Versioned read selector: returns the data of the newest slot whose version is not newer than readVersion.
// Optional hitIdx output is enabled by defining PRIORITY_ROUTER_HIT_IDX_EN.
module priority_router #(
  parameter int DATA_WIDTH    = 32,
  parameter int VERSION_WIDTH = 4,
  parameter int VERSION_NUM   = 4,
  localparam int IDX_W        = (VERSION_NUM > 1) ? $clog2(VERSION_NUM) : 1
) (
  input  logic                                 clk,
  input  logic                                 rstN,
  input  logic                                 inValid,
  input  logic [VERSION_WIDTH*VERSION_NUM-1:0] versions,
  input  logic [DATA_WIDTH*VERSION_NUM-1:0]    dataInputs,
  input  logic [VERSION_WIDTH-1:0]             readVersion,
  output logic                                 outValid,
  output logic [DATA_WIDTH-1:0]                dataOut,
  output logic                                 hit
`ifdef PRIORITY_ROUTER_HIT_IDX_EN
  ,
  output logic [IDX_W-1:0]                     hitIdx
`endif
);

  logic                     sel_hit_s;
  logic [VERSION_WIDTH-1:0] sel_ver_s;
  logic [VERSION_WIDTH-1:0] slot_ver_s;
  logic [DATA_WIDTH-1:0]    sel_data_s;

  logic                     valid_d, valid_q;
  logic                     hit_d, hit_q;
  logic [DATA_WIDTH-1:0]    data_d, data_q;

`ifdef PRIORITY_ROUTER_HIT_IDX_EN
  logic [IDX_W-1:0]         sel_idx_s;
  logic [IDX_W-1:0]         idx_d, idx_q;
`endif

  // Scan slots upward; strict '>' keeps the lowest index among equal versions.
  always_comb begin
    sel_hit_s  = 1'b0;
    sel_ver_s  = {VERSION_WIDTH{1'b0}};
    slot_ver_s = {VERSION_WIDTH{1'b0}};
    sel_data_s = {DATA_WIDTH{1'b0}};
`ifdef PRIORITY_ROUTER_HIT_IDX_EN
    sel_idx_s  = {IDX_W{1'b0}};
`endif
    for (int j = 0; j < VERSION_NUM; j++) begin
      slot_ver_s = versions[j*VERSION_WIDTH +: VERSION_WIDTH];
      if ((slot_ver_s <= readVersion) && (!sel_hit_s || (slot_ver_s > sel_ver_s))) begin
        sel_hit_s  = 1'b1;
        sel_ver_s  = slot_ver_s;
        sel_data_s = dataInputs[j*DATA_WIDTH +: DATA_WIDTH];
`ifdef PRIORITY_ROUTER_HIT_IDX_EN
        sel_idx_s  = IDX_W'(j);
`endif
      end else begin
        sel_hit_s  = sel_hit_s;
      end
    end
  end

  // Next-state: capture the selection on a request, otherwise hold the result.
  always_comb begin
    valid_d = inValid;
    hit_d   = hit_q;
    data_d  = data_q;
`ifdef PRIORITY_ROUTER_HIT_IDX_EN
    idx_d   = idx_q;
`endif
    if (inValid) begin
      hit_d  = sel_hit_s;
      data_d = sel_data_s;
`ifdef PRIORITY_ROUTER_HIT_IDX_EN
      idx_d  = sel_idx_s;
`endif
    end else begin
      hit_d  = hit_q;
    end
  end

  // Output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      valid_q <= 1'b0;
      hit_q   <= 1'b0;
      data_q  <= {DATA_WIDTH{1'b0}};
`ifdef PRIORITY_ROUTER_HIT_IDX_EN
      idx_q   <= {IDX_W{1'b0}};
`endif
    end else begin
      valid_q <= valid_d;
      hit_q   <= hit_d;
      data_q  <= data_d;
`ifdef PRIORITY_ROUTER_HIT_IDX_EN
      idx_q   <= idx_d;
`endif
    end
  end

  assign outValid = valid_q;
  assign hit      = hit_q;
  assign dataOut  = data_q;
`ifdef PRIORITY_ROUTER_HIT_IDX_EN
  assign hitIdx   = idx_q;
`endif

endmodule

// File: tb/tb_priority_router.sv
// Randomized self-checking bench for priority_router against a search-by-version reference model.
// Exercises hitIdx too when PRIORITY_ROUTER_HIT_IDX_EN is defined.
module tb_priority_router;

  logic         clk;
  logic         rstN;
  logic         inValid;
  logic [15:0]  versions;
  logic [127:0] dataInputs;
  logic [3:0]   readVersion;
  logic         outValid;
  logic [31:0]  dataOut;
  logic         hit;
`ifdef PRIORITY_ROUTER_HIT_IDX_EN
  logic [1:0]   hitIdx;
`endif

  int tests;
  int fails;

  // Model of the output registers
  logic        m_valid;
  logic        m_hit;
  logic [31:0] m_data;
  int          m_idx;

  priority_router #(
    .DATA_WIDTH   (32),
    .VERSION_WIDTH(4),
    .VERSION_NUM  (4)
  ) dut (
    .clk        (clk),
    .rstN       (rstN),
    .inValid    (inValid),
    .versions   (versions),
    .dataInputs (dataInputs),
    .readVersion(readVersion),
    .outValid   (outValid),
    .dataOut    (dataOut),
    .hit        (hit)
`ifdef PRIORITY_ROUTER_HIT_IDX_EN
    ,
    .hitIdx     (hitIdx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Search downward from readVersion; the first version value present wins, lowest slot first.
  function automatic void ref_select(input logic [15:0] v, input logic [127:0] d,
                                     input logic [3:0] rv, output logic h,
                                     output logic [31:0] dat, output int idx);
    h = 1'b0;
    dat = 32'd0;
    idx = 0;
    for (int cand = int'(rv); cand >= 0 && !h; cand--) begin
      for (int j = 0; j < 4 && !h; j++) begin
        if (int'(v[j*4 +: 4]) == cand) begin
          h = 1'b1;
          dat = d[j*32 +: 32];
          idx = j;
        end
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".outValid"}, {31'd0, outValid}, {31'd0, m_valid});
    check({tag, ".hit"}, {31'd0, hit}, {31'd0, m_hit});
    check({tag, ".dataOut"}, dataOut, m_data);
`ifdef PRIORITY_ROUTER_HIT_IDX_EN
    check({tag, ".hitIdx"}, {30'd0, hitIdx}, 32'(m_idx));
`endif
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_hit   = 1'b0;
    m_data  = 32'd0;
    m_idx   = 0;
  endtask

  // One clock: update the model from the sampled inputs, then compare just after the edge.
  task automatic cycle(input string tag);
    logic        h;
    logic [31:0] dat;
    int          idx;
    @(posedge clk);
    if (rstN) begin
      if (inValid) begin
        ref_select(versions, dataInputs, readVersion, h, dat, idx);
        m_valid = 1'b1;
        m_hit   = h;
        m_data  = dat;
        m_idx   = h ? idx : 0;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    compare_model(tag);
  endtask

  task automatic set_req(input logic [3:0] v3, input logic [3:0] v2, input logic [3:0] v1,
                         input logic [3:0] v0, input logic [31:0] d3, input logic [31:0] d2,
                         input logic [31:0] d1, input logic [31:0] d0, input logic [3:0] rv);
    inValid     = 1'b1;
    versions    = {v3, v2, v1, v0};
    dataInputs  = {d3, d2, d1, d0};
    readVersion = rv;
  endtask

  task automatic lit(input string tag, input logic v, input logic h, input logic [31:0] d,
                     input logic [31:0] idx);
    check({tag, ".lit_valid"}, {31'd0, outValid}, {31'd0, v});
    check({tag, ".lit_hit"}, {31'd0, hit}, {31'd0, h});
    check({tag, ".lit_data"}, dataOut, d);
`ifdef PRIORITY_ROUTER_HIT_IDX_EN
    check({tag, ".lit_idx"}, {30'd0, hitIdx}, idx);
`endif
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rstN = 1'b0;
    inValid = 1'b0;
    versions = 16'd0;
    dataInputs = 128'd0;
    readVersion = 4'd0;
    model_reset();
    #1;
    lit("reset", 1'b0, 1'b0, 32'd0, 32'd0);
    cycle("in_reset");
    cycle("in_reset2");
    rstN = 1'b1;

    set_req(4'd3, 4'd9, 4'd5, 4'd1, 32'd40, 32'd30, 32'd20, 32'd10, 4'd6);
    cycle("basic");
    lit("basic", 1'b1, 1'b1, 32'd20, 32'd1);
    readVersion = 4'd9;
    cycle("exact");
    lit("exact", 1'b1, 1'b1, 32'd30, 32'd2);
    readVersion = 4'd15;
    cycle("max_rv");
    lit("max_rv", 1'b1, 1'b1, 32'd30, 32'd2);
    readVersion = 4'd1;
    cycle("low_rv");
    lit("low_rv", 1'b1, 1'b1, 32'd10, 32'd0);

    set_req(4'd4, 4'd7, 4'd5, 4'd6, 32'd40, 32'd30, 32'd20, 32'd10, 4'd3);
    cycle("miss");
    lit("miss", 1'b1, 1'b0, 32'd0, 32'd0);

    set_req(4'd2, 4'd5, 4'd5, 4'd1, 32'd4, 32'd3, 32'd2, 32'd1, 4'd5);
    cycle("tie");
    lit("tie", 1'b1, 1'b1, 32'd2, 32'd1);

    set_req(4'd3, 4'd9, 4'd5, 4'd1, 32'd40, 32'd30, 32'd20, 32'd10, 4'd6);
    cycle("pulse");
    inValid = 1'b0;
    versions = 'x;
    dataInputs = 'x;
    readVersion = 'x;
    cycle("hold1");
    lit("hold1", 1'b0, 1'b1, 32'd20, 32'd1);
    versions = 16'h0000;
    dataInputs = {4{32'hdead_beef}};
    readVersion = 4'hf;
    cycle("hold2");
    lit("hold2", 1'b0, 1'b1, 32'd20, 32'd1);

    for (int n = 0; n < 300; n++) begin
      inValid = ($urandom_range(0, 3) != 0);
      versions = 16'($urandom);
      if ($urandom_range(0, 1) == 1) versions = versions & 16'h3333;
      dataInputs = {$urandom, $urandom, $urandom, $urandom};
      readVersion = 4'($urandom);
      cycle("random");
    end

    set_req(4'd3, 4'd9, 4'd5, 4'd1, 32'd40, 32'd30, 32'd20, 32'd10, 4'd6);
    cycle("pre_reset");
    lit("pre_reset", 1'b1, 1'b1, 32'd20, 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    model_reset();
    lit("async_reset", 1'b0, 1'b0, 32'd0, 32'd0);
    cycle("reset_req");
    #2;
    rstN = 1'b1;
    inValid = 1'b0;
    cycle("post_release_idle");
    lit("post_release_idle", 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(4'd3, 4'd9, 4'd5, 4'd1, 32'd40, 32'd30, 32'd20, 32'd10, 4'd6);
    cycle("post_release_req");
    lit("post_release_req", 1'b1, 1'b1, 32'd20, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
